// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for the single-cycle RV32I core.
// Conditions three push-buttons, gates the core through cpu_en, stops on a
// PC breakpoint or an EBREAK, and counts retired instructions.
`timescale 1ns/1ps
module cpu_run_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_halt,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic        ebreak_hit,
  output logic [31:0] retired_cnt
);

  localparam logic [31:0]      EBREAK_INSN = 32'h0010_0073;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  state_t cur_state, next_state;

  // Button vectors use bit 0 = run, bit 1 = step, bit 2 = halt.
  logic [2:0]       btn_raw, sync1, sync2, deb, deb_q, pulse;
  logic [CNT_W-1:0] deb_cnt [3];
  logic             run_p, step_p, halt_p;
  logic             bp_match, ebreak_match, stop, skip;

  assign btn_raw = {btn_halt, btn_step, btn_run};
  assign pulse   = deb & ~deb_q;
  assign run_p   = pulse[0];
  assign step_p  = pulse[1];
  assign halt_p  = pulse[2];

  // Synchronize each button, then accept a new level only after the
  // synchronized level has disagreed with the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A stop is suppressed while skip is set so the core can step past the
  // instruction it last stopped on.
  assign bp_match     = bp_en && (pc == bp_addr);
  assign ebreak_match = (instruction == EBREAK_INSN);
  assign stop         = ~skip & (bp_match | ebreak_match);
  assign cpu_en       = ((cur_state == ST_RUN) & ~stop) | (cur_state == ST_STEP);
  assign state        = cur_state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur_state <= ST_HALT;
    else     cur_state <= next_state;
  end

  // Next-state logic; coincident pulses resolve halt > step > run.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_RUN: begin
        if (halt_p)    next_state = ST_HALT;
        else if (stop) next_state = ST_BREAK;
      end
      ST_STEP: next_state = ST_HALT;
      default: begin
        if (halt_p)      next_state = ST_HALT;
        else if (step_p) next_state = ST_STEP;
        else if (run_p)  next_state = ST_RUN;
      end
    endcase
  end

  // Sticky stop-cause flags: record the cause on entry to BREAK, clear on
  // any run or step request.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit     <= 1'b0;
      ebreak_hit <= 1'b0;
    end else if ((cur_state == ST_RUN) && !halt_p && stop) begin
      bp_hit     <= bp_match;
      ebreak_hit <= ebreak_match;
    end else if (run_p || step_p) begin
      bp_hit     <= 1'b0;
      ebreak_hit <= 1'b0;
    end
  end

  // Skip is armed when leaving BREAK for RUN or STEP and disarmed once the
  // core has advanced by one instruction (or on a halt request).
  always_ff @(posedge clk) begin
    if (rst) begin
      skip <= 1'b0;
    end else if ((cur_state == ST_BREAK) &&
                 ((next_state == ST_RUN) || (next_state == ST_STEP))) begin
      skip <= 1'b1;
    end else if (cpu_en || halt_p) begin
      skip <= 1'b0;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk) begin
    if (rst)         retired_cnt <= '0;
    else if (cpu_en) retired_cnt <= retired_cnt + 32'd1;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed scenarios followed by randomized
// button/program traffic, all compared cycle by cycle against a reference model.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  localparam int          D           = 4;
  localparam int          W           = 37;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam int          S_HALT      = 0;
  localparam int          S_RUN       = 1;
  localparam int          S_STEP      = 2;
  localparam int          S_BREAK     = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        btn_run  = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_halt = 1'b0;
  logic        bp_en    = 1'b0;
  logic [31:0] bp_addr  = '0;
  logic [31:0] pc       = '0;
  logic [31:0] instruction;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic        ebreak_hit;
  logic [31:0] retired_cnt;

  logic [31:0] imem [64];
  assign instruction = imem[pc[7:2]];

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
    .btn_halt   (btn_halt),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .instruction(instruction),
    .cpu_en     (cpu_en),
    .state      (state),
    .bp_hit     (bp_hit),
    .ebreak_hit (ebreak_hit),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks  = 0;
  int errors  = 0;
  int mon_cyc = 0;

  // ---------------- reference model ----------------
  int          m_state = S_HALT;
  bit          m_skip, m_bp, m_eb, m_valid;
  logic [31:0] m_ret   = '0;
  bit   [2:0]  m_deb, m_pulse;
  bit   [2:0]  raw_q[$];
  bit   [2:0]  sync_q[$];
  logic [31:0] next_pc = '0;
  bit          cfg_bp_en   = 1'b0;
  logic [31:0] cfg_bp_addr = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, record the expected outputs for this
  // cycle, then advance the model to the following cycle.
  task automatic tick(input bit r, input bit [2:0] b);
    bit          bp_c, eb_c, stop_c, en_c, halt_p, step_p, run_p, differ;
    bit   [2:0]  sync_now, new_pulse;
    int          nst;
    logic [31:0] insn;
    @(posedge clk);
    #2;
    pc       = next_pc;
    rst      = r;
    btn_run  = b[0];
    btn_step = b[1];
    btn_halt = b[2];
    bp_en    = cfg_bp_en;
    bp_addr  = cfg_bp_addr;
    insn     = imem[pc[7:2]];
    {halt_p, step_p, run_p} = m_pulse;
    bp_c   = bp_en && (pc == bp_addr);
    eb_c   = (insn == EBREAK_INSN);
    stop_c = !m_skip && (bp_c || eb_c);
    en_c   = ((m_state == S_RUN) && !stop_c) || (m_state == S_STEP);
    if (m_valid) exp_q.push_back({2'(m_state), en_c, m_bp, m_eb, m_ret});
    next_pc = r ? 32'h0 : (en_c ? pc + 32'd4 : pc);
    if (r) begin
      m_state = S_HALT;
      m_skip  = 0;
      m_bp    = 0;
      m_eb    = 0;
      m_ret   = '0;
      m_deb   = '0;
      m_pulse = '0;
      raw_q.delete();
      sync_q.delete();
      m_valid = 1;
    end else begin
      case (m_state)
        S_RUN:   nst = halt_p ? S_HALT : (stop_c ? S_BREAK : S_RUN);
        S_STEP:  nst = S_HALT;
        default: nst = halt_p ? S_HALT : step_p ? S_STEP : run_p ? S_RUN : m_state;
      endcase
      if ((m_state == S_RUN) && !halt_p && stop_c) begin
        m_bp = bp_c;
        m_eb = eb_c;
      end else if (run_p || step_p) begin
        m_bp = 0;
        m_eb = 0;
      end
      if ((m_state == S_BREAK) && ((nst == S_RUN) || (nst == S_STEP))) m_skip = 1;
      else if (en_c || halt_p) m_skip = 0;
      m_ret   = m_ret + (en_c ? 32'd1 : 32'd0);
      m_state = nst;
      // Button: the level seen two samples ago must disagree with the
      // accepted level for D consecutive samples before it is accepted.
      sync_now = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 3'b000;
      raw_q.push_back(b);
      sync_q.push_back(sync_now);
      new_pulse = '0;
      for (int k = 0; k < 3; k++) begin
        if (sync_q.size() >= D) begin
          differ = 1;
          for (int j = 1; j <= D; j++)
            if (sync_q[sync_q.size() - j][k] == m_deb[k]) differ = 0;
          if (differ) begin
            new_pulse[k] = !m_deb[k];
            m_deb[k]     = !m_deb[k];
          end
        end
      end
      m_pulse = new_pulse;
      while (raw_q.size() > 16)  void'(raw_q.pop_front());
      while (sync_q.size() > 16) void'(sync_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 3'b000);
  endtask

  // Hold buttons for 6 cycles then release; the resulting state is visible
  // on the last (8th) cycle.
  task automatic press(input bit [2:0] b);
    for (int i = 0; i < 8; i++) tick(1'b0, (i < 6) ? b : 3'b000);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {state, cpu_en, bp_hit, ebreak_hit, retired_cnt};
        checks++;
        if (g !== e) begin
          errors++;
          if (errors <= 30)
            $display("FAIL scoreboard cycle %0d: got st=%0d en=%0b bp=%0b eb=%0b cnt=0x%0h, expected st=%0d en=%0b bp=%0b eb=%0b cnt=0x%0h",
                     mon_cyc, g[36:35], g[34], g[33], g[32], g[31:0],
                     e[36:35], e[34], e[33], e[32], e[31:0]);
        end
      end
      mon_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit [2:0] lvl;
    int       rem [3];
    int       guard;
    for (int i = 0; i < 64; i++) imem[i] = NOP_INSN;

    // Reset
    tick(1'b1, 3'b000);
    tick(1'b1, 3'b000);
    idle(1);
    #1;
    chk("reset_state", state, S_HALT);
    chk("reset_en", cpu_en, 0);
    chk("reset_cnt", retired_cnt, 0);

    // Run press held 10 cycles: RUN appears exactly 7 cycles after the press
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 3'b001);
      #1;
      if (i == 6) chk("run_latency_before", state, S_HALT);
      if (i == 7) begin
        chk("run_latency_at7", state, S_RUN);
        chk("run_cpu_en", cpu_en, 1);
      end
      if (i == 9) chk("run_cnt_inc", retired_cnt, 2);
    end

    // Halt, then a 3-cycle glitch on run must be ignored
    press(3'b100);
    #1; chk("halt_press", state, S_HALT);
    repeat (3) tick(1'b0, 3'b001);
    idle(15);
    #1; chk("glitch_ignored", state, S_HALT);

    // Single step
    press(3'b010);
    #1; chk("step_state", state, S_STEP);
    chk("step_en", cpu_en, 1);
    idle(1);
    #1; chk("step_back_halt", state, S_HALT);
    chk("step_cnt", retired_cnt, 11);

    // Breakpoint at 0x10, EBREAK at 0x20
    cfg_bp_en   = 1'b1;
    cfg_bp_addr = 32'h10;
    imem[8]     = EBREAK_INSN;
    tick(1'b1, 3'b000);
    idle(1);
    press(3'b001);
    #1; chk("bp_run", state, S_RUN);
    idle(4);
    #1; chk("bp_en_low", cpu_en, 0);
    idle(1);
    #1; chk("bp_state", state, S_BREAK);
    chk("bp_hit", bp_hit, 1);
    chk("bp_eb_clear", ebreak_hit, 0);
    chk("bp_cnt", retired_cnt, 4);
    press(3'b001);
    #1; chk("bp_resume_state", state, S_RUN);
    chk("bp_resume_en", cpu_en, 1);
    chk("bp_hit_cleared", bp_hit, 0);
    idle(4);
    #1; chk("eb_en_low", cpu_en, 0);
    idle(1);
    #1; chk("eb_state", state, S_BREAK);
    chk("eb_hit", ebreak_hit, 1);
    chk("eb_bp_clear", bp_hit, 0);
    press(3'b010);
    #1; chk("eb_step_state", state, S_STEP);
    chk("eb_step_en", cpu_en, 1);
    chk("eb_hit_cleared", ebreak_hit, 0);
    idle(1);
    #1; chk("eb_step_halt", state, S_HALT);
    chk("eb_step_cnt", retired_cnt, 9);

    // Coincident pulses
    idle(8);
    press(3'b001);
    #1; chk("run_again", state, S_RUN);
    idle(8);
    press(3'b101);
    #1; chk("halt_beats_run", state, S_HALT);
    idle(8);
    press(3'b011);
    #1; chk("step_beats_run", state, S_STEP);

    // Reset while running with retired_cnt = 0x123
    cfg_bp_en = 1'b0;
    idle(8);
    imem[8] = NOP_INSN;
    tick(1'b1, 3'b000);
    press(3'b001);
    guard = 0;
    while ((m_ret != 32'h123) && (guard < 2000)) begin
      tick(1'b0, 3'b000);
      guard++;
    end
    tick(1'b1, 3'b000);
    #1; chk("pre_reset_cnt", retired_cnt, 32'h123);
    chk("pre_reset_state", state, S_RUN);
    idle(1);
    #1; chk("mid_reset_state", state, S_HALT);
    chk("mid_reset_en", cpu_en, 0);
    chk("mid_reset_cnt", retired_cnt, 0);
    chk("mid_reset_bp", bp_hit, 0);
    chk("mid_reset_eb", ebreak_hit, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 64; i++)
      imem[i] = ($urandom_range(0, 7) == 0) ? EBREAK_INSN : $urandom();
    lvl = '0;
    for (int k = 0; k < 3; k++) rem[k] = $urandom_range(3, 30);
    for (int c = 0; c < 3000; c++) begin
      if ((c % 250) == 0) begin
        cfg_bp_en   = 1'($urandom_range(0, 1));
        cfg_bp_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = !lvl[k];
          if (lvl[k])      rem[k] = $urandom_range(1, 10);
          else if (k == 2) rem[k] = $urandom_range(20, 90);
          else             rem[k] = $urandom_range(3, 40);
        end
        rem[k]--;
      end
      tick(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, lvl);
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
